led_scheduler: RTL and testbench
================================

Name: led_scheduler

Overview:
- Time-shares the board LED bank between N requesters, e.g. the free-running counter display, the reset/button status and future app status patterns.
- Round-robin arbitration with a guaranteed minimum display time (dwell) per owner.
- Outputs are blanked for a short gap between owners so a change of owner is visible.
- Shows a fixed idle pattern when nobody requests; sits directly in front of the top-level leds register.

Parameters:
- N, 4, number of requesters (2..8).
- WIDTH, 8, LED bank width.
- DWELL, 26, minimum hold time is 2^DWELL clock cycles (about 0.5 s at 133 MHz).
- GAP, 20, blank time between owners is 2^GAP clock cycles; GAP >= 1.
- IDLE_PATTERN, 8'b10101010, leds value in IDLE.

Ports:
- clock  input  1  system clock (OSCH output).
- reset  input  1  synchronous, active-high reset.
- req  input  N  request per requester; level, held while the requester wants the display.
- data  input  N*WIDTH  pattern per requester; requester i occupies bits [i*WIDTH +: WIDTH].
- leds  output  WIDTH  registered LED drive.
- grant  output  N  registered one-hot owner; all zero outside SHOW.
- busy  output  1  registered; high when state is not IDLE.

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE, leds=IDLE_PATTERN, grant=0, busy=0, timer=0.
  - last=N-1, so requester 0 wins first after reset.
  - Reset asserted mid-SHOW or mid-GAP takes effect on the next edge with the same values.
- Round-robin pick: the lowest index at or after (last+1) mod N with req set, wrapping. It is combinational from the current req.
- IDLE:
  - leds=IDLE_PATTERN.
  - If any req: on the next edge go to SHOW with owner=pick, grant=onehot(pick), last=pick, timer=0.
  - Latency from req rising to grant: 1 cycle. leds follow in the same edge, loaded with data[pick].
- SHOW:
  - Every edge, leds <= data[owner]: live tracking with 1-cycle latency.
  - timer increments.
  - Expiry = timer == 2^DWELL-1.
  - If req[owner] drops before expiry: go to GAP on the next edge. An early release is allowed.
  - At expiry with any other req set: go to GAP.
  - At expiry with only the owner requesting: stay in SHOW. timer wraps to 0 and grant is not deasserted.
  - At expiry with no req: go to GAP.
  - Owner drop in the same cycle as expiry: go to GAP.
- GAP:
  - leds=0, grant=0, busy=1, timer counts 0..2^GAP-1.
  - req changes during GAP are ignored until the final gap cycle.
  - On the final cycle: if any req, go to SHOW using the pick from last, with timer=0. Otherwise go to IDLE.
  - The previous owner may win again only if no other requester is pending.
- timer:
  - Width max(DWELL,GAP)+1.
  - Cleared on every state change; never saturates silently.
- data of non-owners is don't-care. X on non-owner data must not propagate to leds.

Decomposition:
- Shared include/package led_sched_defs: state encodings ST_IDLE=2'd0, ST_SHOW=2'd1, ST_GAP=2'd2, and the timer width function.
- One sub-module rr_pick: combinational round-robin picker.
  - Parameter N; inputs req[N] and last index.
  - Outputs any and pick index.
  - Reused later for other shared board resources.
- The state machine, timer and output registers stay in led_scheduler.

Test Plan (bench parameters N=4, DWELL=3 giving 8 cycles, GAP=1 giving 2 cycles):
- Reset held 3 cycles with req=4'b1111 -> leds=8'hAA, grant=0, busy=0 throughout. First grant=4'b0001 one cycle after reset is released.
- req=4'b0100 alone with data2=8'h5A -> grant=4'b0100 after 1 cycle, leds=8'h5A. Stays granted indefinitely across dwell expiries with no gap.
- req=4'b0011 held -> owners alternate 0,1,0,1. Each SHOW lasts exactly 8 cycles, each separated by exactly 2 cycles of leds=0 and grant=0.
- Owner 1 drops req on cycle 3 of SHOW while req0 is set -> GAP starts next cycle; after 2 cycles grant=4'b0001.
- Owner changes data mid-SHOW from 8'h01 to 8'h80 -> leds show 8'h80 exactly one cycle later.
- All req drop during SHOW -> 2-cycle GAP, then IDLE with leds=8'hAA and busy=0. Reset asserted mid-GAP -> IDLE next edge, last=3.

Source files
------------

// File: rtl/led_sched_defs.sv
// Shared definitions for the LED bank scheduler.
// State encodings and timer sizing helper.
package led_sched_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Timer must reach the larger of the dwell and gap end counts.
    function automatic int timer_w(input int dwell, input int gap);
        return ((dwell > gap) ? dwell : gap) + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Lowest requester at or after (last+1) mod N, wrapping.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 any,
    output logic [$clog2(N)-1:0] pick
);

    localparam int LW = $clog2(N);

    // Scan from farthest to nearest so the nearest hit wins.
    always_comb begin
        logic [LW-1:0] w_idx;
        any  = |req;
        pick = last;
        for (int k = N; k >= 1; k--) begin
            w_idx = LW'((int'(last) + k) % N);
            if (req[w_idx]) begin
                pick = w_idx;
            end
        end
    end

endmodule

// File: rtl/led_scheduler.sv
// Time-shares the LED bank between N requesters with
// round-robin ownership, minimum dwell and a blank gap.
module led_scheduler
    import led_sched_defs::*;
#(
    parameter int               N            = 4,
    parameter int               WIDTH        = 8,
    parameter int               DWELL        = 26,
    parameter int               GAP          = 20,
    parameter logic [WIDTH-1:0] IDLE_PATTERN = 8'b10101010
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] data,
    output logic [WIDTH-1:0]   leds,
    output logic [N-1:0]       grant,
    output logic               busy
);

    localparam int LW = $clog2(N);
    localparam int TW = timer_w(DWELL, GAP);
    localparam logic [TW-1:0] DW_END = TW'((1 << DWELL) - 1);
    localparam logic [TW-1:0] GP_END = TW'((1 << GAP) - 1);

    state_t           r_state;
    state_t           w_state_nx;
    logic [LW-1:0]    r_owner;
    logic [LW-1:0]    w_owner_nx;
    logic [LW-1:0]    r_last;
    logic [LW-1:0]    w_last_nx;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer_nx;
    logic [WIDTH-1:0] r_leds;
    logic [WIDTH-1:0] w_leds_nx;
    logic [N-1:0]     r_grant;
    logic [N-1:0]     w_grant_nx;
    logic             r_busy;

    logic             w_any;
    logic [LW-1:0]    w_pick;
    logic [WIDTH-1:0] w_slot [N];
    logic             w_others;

    rr_pick #(.N(N)) u_pick (
        .req  (req),
        .last (r_last),
        .any  (w_any),
        .pick (w_pick)
    );

    // Per-requester view of the packed data bus.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_slot[i] = data[i*WIDTH +: WIDTH];
        end
    end

    assign w_others = |(req & ~(N'(1) << r_owner));

    // Next-state, timer and output register values.
    always_comb begin
        w_state_nx = r_state;
        w_owner_nx = r_owner;
        w_last_nx  = r_last;
        w_timer_nx = r_timer + TW'(1);
        w_leds_nx  = r_leds;
        w_grant_nx = r_grant;
        unique case (r_state)
            ST_IDLE: begin
                w_timer_nx = '0;
                w_leds_nx  = IDLE_PATTERN;
                w_grant_nx = '0;
                if (w_any) begin
                    w_state_nx = ST_SHOW;
                    w_owner_nx = w_pick;
                    w_last_nx  = w_pick;
                    w_leds_nx  = w_slot[w_pick];
                    w_grant_nx = N'(1) << w_pick;
                end
            end
            ST_SHOW: begin
                w_leds_nx = w_slot[r_owner];
                if (!req[r_owner] ||
                    (r_timer == DW_END && w_others)) begin
                    w_state_nx = ST_GAP;
                    w_timer_nx = '0;
                    w_leds_nx  = '0;
                    w_grant_nx = '0;
                end else if (r_timer == DW_END) begin
                    w_timer_nx = '0;
                end
            end
            ST_GAP: begin
                w_leds_nx  = '0;
                w_grant_nx = '0;
                if (r_timer == GP_END) begin
                    w_timer_nx = '0;
                    if (w_any) begin
                        w_state_nx = ST_SHOW;
                        w_owner_nx = w_pick;
                        w_last_nx  = w_pick;
                        w_leds_nx  = w_slot[w_pick];
                        w_grant_nx = N'(1) << w_pick;
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_leds_nx  = IDLE_PATTERN;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_timer_nx = '0;
                w_leds_nx  = IDLE_PATTERN;
                w_grant_nx = '0;
            end
        endcase
    end

    // State and registered outputs; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_last  <= LW'(N - 1);
            r_timer <= '0;
            r_leds  <= IDLE_PATTERN;
            r_grant <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_owner <= w_owner_nx;
            r_last  <= w_last_nx;
            r_timer <= w_timer_nx;
            r_leds  <= w_leds_nx;
            r_grant <= w_grant_nx;
            r_busy  <= (w_state_nx != ST_IDLE);
        end
    end

    assign leds  = r_leds;
    assign grant = r_grant;
    assign busy  = r_busy;

endmodule

// File: tb/tb_led_scheduler.sv
// Scoreboard bench for led_scheduler (N=4, 8-cycle dwell,
// 2-cycle gap) with hand-computed per-cycle expectations.
module tb_led_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req   = 4'b0000;
    logic [31:0] data  = 32'h0;
    logic [31:0] dv    = 32'h0;
    wire  [7:0]  leds;
    wire  [3:0]  grant;
    wire         busy;

    logic [12:0] exp_q [$];
    string       name_q [$];
    int          checks   = 0;
    int          failures = 0;
    logic [12:0] mon_e;
    string       mon_n;

    led_scheduler #(
        .N            (4),
        .WIDTH        (8),
        .DWELL        (3),
        .GAP          (1),
        .IDLE_PATTERN (8'hAA)
    ) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .data  (data),
        .leds  (leds),
        .grant (grant),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    // Drive one cycle of inputs and queue the outputs expected
    // after the following clock edge.
    task automatic cyc(input logic r, input logic [3:0] rq,
                       input logic [7:0] el, input logic [3:0] eg,
                       input logic eb, input string nm);
        @(posedge clock);
        #2;
        reset = r;
        req   = rq;
        data  = dv;
        exp_q.push_back({el, eg, eb});
        name_q.push_back(nm);
    endtask

    // Monitor: compare every presented output cycle with the queue.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                checks++;
                if ({leds, grant, busy} !== mon_e) begin
                    failures++;
                    $display("FAIL %s: leds=%h grant=%b busy=%b want leds=%h grant=%b busy=%b",
                             mon_n, leds, grant, busy,
                             mon_e[12:5], mon_e[4:1], mon_e[0]);
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic [3:0] g;
        dv = {8'h33, 8'h5A, 8'h22, 8'h01};
        data = dv;

        repeat (3) cyc(1'b1, 4'b1111, 8'hAA, 4'b0000, 1'b0, "reset_hold");
        cyc(1'b0, 4'b1111, 8'h01, 4'b0001, 1'b1, "first_grant");
        cyc(1'b1, 4'b0000, 8'hAA, 4'b0000, 1'b0, "reset_mid_show");

        cyc(1'b0, 4'b0100, 8'h5A, 4'b0100, 1'b1, "solo_grant");
        repeat (20) cyc(1'b0, 4'b0100, 8'h5A, 4'b0100, 1'b1, "solo_hold");
        cyc(1'b0, 4'b0000, 8'h00, 4'b0000, 1'b1, "drop_gap0");
        cyc(1'b0, 4'b0000, 8'h00, 4'b0000, 1'b1, "drop_gap1");
        cyc(1'b0, 4'b0000, 8'hAA, 4'b0000, 1'b0, "idle_after_gap");

        for (int b = 0; b < 3; b++) begin
            d = (b == 1) ? 8'h22 : 8'h01;
            g = (b == 1) ? 4'b0010 : 4'b0001;
            repeat (8) cyc(1'b0, 4'b0011, d, g, 1'b1, "rr_show");
            repeat (2) cyc(1'b0, 4'b0011, 8'h00, 4'b0000, 1'b1, "rr_gap");
        end

        repeat (3) cyc(1'b0, 4'b0011, 8'h22, 4'b0010, 1'b1, "early_show");
        cyc(1'b0, 4'b0001, 8'h00, 4'b0000, 1'b1, "early_gap0");
        cyc(1'b0, 4'b0001, 8'h00, 4'b0000, 1'b1, "early_gap1");
        cyc(1'b0, 4'b0001, 8'h01, 4'b0001, 1'b1, "early_regrant");

        cyc(1'b0, 4'b0001, 8'h01, 4'b0001, 1'b1, "data_before");
        dv[7:0] = 8'h80;
        cyc(1'b0, 4'b0001, 8'h80, 4'b0001, 1'b1, "data_change");
        cyc(1'b0, 4'b0001, 8'h80, 4'b0001, 1'b1, "data_hold");

        cyc(1'b0, 4'b0000, 8'h00, 4'b0000, 1'b1, "gap_before_reset");
        cyc(1'b1, 4'b0001, 8'hAA, 4'b0000, 1'b0, "reset_mid_gap");
        dv[31:24] = 8'hxx;
        cyc(1'b0, 4'b1001, 8'h80, 4'b0001, 1'b1, "last_after_reset");
        cyc(1'b0, 4'b1001, 8'h80, 4'b0001, 1'b1, "x_isolation");
        cyc(1'b1, 4'b0000, 8'hAA, 4'b0000, 1'b0, "final_reset");

        repeat (3) @(posedge clock);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
